mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_pkg.sv | 55 +++++
 rtl/lsu_align.sv | 54 +++++
 rtl/mem_access_unit.sv | 145 ++++++++++++++
 tb/tb_mem_access_unit.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg -- shared definitions for the memory access unit.
//   * RISC-V load/store funct3 encodings
//   * FSM state encoding (2-bit enum)
//   * access size decode and the legality (alignment / encoding) check
// ---------------------------------------------------------------------------
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SZ_B   = 2'd0,
    SZ_H   = 2'd1,
    SZ_W   = 2'd2,
    SZ_BAD = 2'd3
  } size_t;

  function automatic size_t size_decode(input logic [2:0] f3);
    size_t sz;
    case (f3)
      F3_B, F3_BU: sz = SZ_B;
      F3_H, F3_HU: sz = SZ_H;
      F3_W:        sz = SZ_W;
      default:     sz = SZ_BAD;
    endcase
    return sz;
  endfunction

  // Legal = known encoding, naturally aligned, and no unsigned variant on a store.
  function automatic logic access_legal(input logic [2:0] f3,
                                        input logic [1:0] off,
                                        input logic       is_store);
    logic ok;
    case (size_decode(f3))
      SZ_B:    ok = 1'b1;
      SZ_H:    ok = ~off[0];
      SZ_W:    ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    if (is_store && f3[2]) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align -- combinational byte-lane formatting.
//   Store side: st_funct3/st_off/st_data -> replicated st_wdata + st_wstrb.
//   Load side : ld_funct3/ld_off/ld_rdata -> sign/zero-extended ld_ext.
// ---------------------------------------------------------------------------
module lsu_align
  import mem_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_wstrb,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_ext
);

  logic [15:0] ld_shift;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned -- that is what keeps synthesis from inferring a latch.
  always_comb begin
    st_wdata = st_data;
    st_wstrb = 4'b1111;
    case (size_decode(st_funct3))
      SZ_B: begin
        st_wdata = {4{st_data[7:0]}};
        st_wstrb = 4'b0001 << st_off;
      end
      SZ_H: begin
        st_wdata = {2{st_data[15:0]}};
        st_wstrb = st_off[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // Bring the addressed byte/halfword down to lane 0, then extend.
  assign ld_shift = 16'(ld_rdata >> {ld_off, 3'b000});

  always_comb begin
    ld_ext = ld_rdata;
    case (ld_funct3)
      F3_B:    ld_ext = {{24{ld_shift[7]}}, ld_shift[7:0]};
      F3_BU:   ld_ext = {24'b0, ld_shift[7:0]};
      F3_H:    ld_ext = {{16{ld_shift[15]}}, ld_shift[15:0]};
      F3_HU:   ld_ext = {16'b0, ld_shift[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit -- MEM-stage load/store unit in front of a data cache.
//   Pipeline side : valid, mem_read, mem_write, funct3, alu_out_in (address),
//                   rs2_data_in (store data), current_pc_in; stall_cache holds
//                   EX/MEM while an access is in flight.
//   Cache side    : dc_req/dc_we/dc_addr/dc_wdata/dc_wstrb out, dc_ready,
//                   dc_rvalid/dc_rdata in.
//   Results       : ld_data/ld_valid (completion), acc_exc/exc_pc/exc_addr.
//   rst is asynchronous, active low. Only XLEN = 32 is supported.
// ---------------------------------------------------------------------------
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] alu_out_in,
  input  logic [XLEN-1:0] rs2_data_in,
  input  logic [XLEN-1:0] current_pc_in,
  output logic            dc_req,
  output logic            dc_we,
  output logic [XLEN-1:0] dc_addr,
  output logic [XLEN-1:0] dc_wdata,
  output logic [3:0]      dc_wstrb,
  input  logic            dc_ready,
  input  logic            dc_rvalid,
  input  logic [XLEN-1:0] dc_rdata,
  output logic [XLEN-1:0] ld_data,
  output logic            ld_valid,
  output logic            stall_cache,
  output logic            acc_exc,
  output logic [XLEN-1:0] exc_pc,
  output logic [XLEN-1:0] exc_addr
);

  state_t      state, state_nxt;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic        is_store, start, legal, go, fault, capture_ld;
  logic [31:0] st_wdata, ld_ext;
  logic [3:0]  st_wstrb;

  // A read wins when both request bits are set. start is gated by rst so the
  // combinational stall stays low while reset is asserted.
  assign is_store = mem_write & ~mem_read;
  assign start    = rst & valid & (mem_read | mem_write) & (state == IDLE);
  assign legal    = access_legal(funct3, alu_out_in[1:0], is_store);
  assign go       = start & legal;
  assign fault    = start & ~legal;

  lsu_align u_align (
    .st_funct3 (funct3),
    .st_off    (alu_out_in[1:0]),
    .st_data   (rs2_data_in),
    .st_wdata  (st_wdata),
    .st_wstrb  (st_wstrb),
    .ld_funct3 (r_funct3),
    .ld_off    (r_off),
    .ld_rdata  (dc_rdata),
    .ld_ext    (ld_ext)
  );

  always_comb begin
    state_nxt   = state;
    dc_req      = 1'b0;
    stall_cache = 1'b0;
    ld_valid    = 1'b0;
    capture_ld  = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          state_nxt   = REQ;
          stall_cache = 1'b1;
        end
      end
      REQ: begin
        dc_req      = 1'b1;
        stall_cache = 1'b1;
        // A response without acceptance is not ours and is dropped.
        if (dc_ready) begin
          if (dc_rvalid) begin
            state_nxt  = DONE;
            capture_ld = ~dc_we;
          end else begin
            state_nxt  = WAIT;
          end
        end
      end
      WAIT: begin
        stall_cache = 1'b1;
        if (dc_rvalid) begin
          state_nxt  = DONE;
          capture_ld = ~dc_we;
        end
      end
      DONE: begin
        ld_valid  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: datapath registers are reset too, not just the FSM, because they
      // drive outputs that must read 0 during reset.
      state    <= IDLE;
      dc_we    <= 1'b0;
      dc_addr  <= '0;
      dc_wdata <= '0;
      dc_wstrb <= 4'b0;
      r_funct3 <= 3'b0;
      r_off    <= 2'b0;
      ld_data  <= '0;
      acc_exc  <= 1'b0;
      exc_pc   <= '0;
      exc_addr <= '0;
    end else begin
      state   <= state_nxt;
      acc_exc <= fault;
      if (go) begin
        dc_we    <= is_store;
        dc_addr  <= {alu_out_in[XLEN-1:2], 2'b00};
        dc_wdata <= st_wdata;
        dc_wstrb <= is_store ? st_wstrb : 4'b0000;
        r_funct3 <= funct3;
        r_off    <= alu_out_in[1:0];
      end
      if (fault) begin
        exc_pc   <= current_pc_in;
        exc_addr <= alu_out_in;
      end
      if (capture_ld) ld_data <= ld_ext;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit -- directed and randomized checks of mem_access_unit
// against an arithmetic reference model of the load/store rules.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst, valid, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] alu_out_in, rs2_data_in, current_pc_in;
  logic        dc_req, dc_we, dc_ready, dc_rvalid;
  logic [31:0] dc_addr, dc_wdata, dc_rdata, ld_data, exc_pc, exc_addr;
  logic [3:0]  dc_wstrb;
  logic        ld_valid, stall_cache, acc_exc;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_ld = 32'h0;

  mem_access_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .valid(valid), .mem_read(mem_read),
    .mem_write(mem_write), .funct3(funct3), .alu_out_in(alu_out_in),
    .rs2_data_in(rs2_data_in), .current_pc_in(current_pc_in),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_wstrb(dc_wstrb), .dc_ready(dc_ready), .dc_rvalid(dc_rvalid),
    .dc_rdata(dc_rdata), .ld_data(ld_data), .ld_valid(ld_valid),
    .stall_cache(stall_cache), .acc_exc(acc_exc), .exc_pc(exc_pc),
    .exc_addr(exc_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // ---- reference model: sizes in bytes, plain arithmetic ----
  function automatic int unsigned acc_bytes(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit model_legal(input logic [2:0] f3, input logic [31:0] a, input bit store);
    bit known;
    known = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    if (!known) return 1'b0;
    if (store && f3 > 3'd2) return 1'b0;
    return (a % acc_bytes(f3)) == 0;
  endfunction

  function automatic logic [3:0] model_wstrb(input logic [2:0] f3, input logic [31:0] a);
    int unsigned n;
    n = acc_bytes(f3);
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] rs2, input logic [2:0] f3);
    logic [31:0] w;
    int unsigned n;
    n = acc_bytes(f3);
    w = 32'h0;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = rs2[8*(k % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rdat, input logic [2:0] f3,
                                             input logic [31:0] a);
    int unsigned n, off;
    logic [31:0] v, mask;
    n    = acc_bytes(f3);
    off  = a % 4;
    if (n == 4) return rdat;
    mask = (32'd1 << (8 * n)) - 32'd1;
    v    = (rdat >> (8 * off)) & mask;
    if (!f3[2] && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  // One instruction from IDLE to completion (or fault), cycle by cycle.
  task automatic run_op(input logic vld, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdat, input logic [31:0] pc,
                        input logic [31:0] rdat, input int rdy_wait, input int rv_wait,
                        input bit same);
    bit active, store, legal;
    active = vld && (rd || wr);
    store  = wr && !rd;
    legal  = model_legal(f3, addr, store);
    valid = vld; mem_read = rd; mem_write = wr; funct3 = f3;
    alu_out_in = addr; rs2_data_in = wdat; current_pc_in = pc;
    dc_ready = 1'b0; dc_rvalid = 1'b0;
    @(negedge clk);
    check_bit("idle_stall", stall_cache, active && legal);
    check_bit("idle_req", dc_req, 1'b0);
    check_bit("exc_clear", acc_exc, 1'b0);
    @(posedge clk); #1;
    if (!(active && legal)) begin
      valid = 1'b0;
      @(negedge clk);
      check_bit("exc_pulse", acc_exc, active);
      if (active) begin
        check("exc_pc", exc_pc, pc);
        check("exc_addr", exc_addr, addr);
      end
      check_bit("exc_no_req", dc_req, 1'b0);
      check_bit("exc_stall", stall_cache, 1'b0);
      check("exc_ld_hold", ld_data, model_ld);
      @(posedge clk); #1;
      return;
    end
    for (int i = 0; i <= rdy_wait; i++) begin
      dc_ready  = (i == rdy_wait);
      dc_rvalid = (i == rdy_wait) ? same : 1'($urandom_range(0, 1));
      dc_rdata  = (i == rdy_wait) ? rdat : $urandom;
      @(negedge clk);
      check_bit("req_req", dc_req, 1'b1);
      check("req_addr", dc_addr, addr & 32'hFFFF_FFFC);
      check_bit("req_we", dc_we, store);
      if (store) begin
        check("req_wdata", dc_wdata, model_wdata(wdat, f3));
        check("req_wstrb", {28'h0, dc_wstrb}, {28'h0, model_wstrb(f3, addr)});
      end
      check_bit("req_stall", stall_cache, 1'b1);
      check_bit("req_ldv", ld_valid, 1'b0);
      @(posedge clk); #1;
    end
    if (!same) begin
      for (int i = 0; i <= rv_wait; i++) begin
        dc_ready  = 1'($urandom_range(0, 1));
        dc_rvalid = (i == rv_wait);
        dc_rdata  = (i == rv_wait) ? rdat : $urandom;
        @(negedge clk);
        check_bit("wait_req", dc_req, 1'b0);
        check_bit("wait_stall", stall_cache, 1'b1);
        check_bit("wait_ldv", ld_valid, 1'b0);
        @(posedge clk); #1;
      end
    end
    dc_ready  = 1'b0;
    dc_rvalid = 1'($urandom_range(0, 1));
    dc_rdata  = $urandom;
    if (!store) model_ld = model_load(rdat, f3, addr);
    @(negedge clk);
    check_bit("done_ldv", ld_valid, 1'b1);
    check_bit("done_stall", stall_cache, 1'b0);
    check_bit("done_req", dc_req, 1'b0);
    check("done_ld_data", ld_data, model_ld);
    @(posedge clk); #1;
  endtask

  logic [2:0]  r_f3;
  logic [31:0] r_addr;
  logic        r_vld, r_rd, r_wr;

  initial begin
    rst = 1'b0; valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010;
    alu_out_in = 32'h100; rs2_data_in = 32'h0; current_pc_in = 32'h0;
    dc_ready = 1'b0; dc_rvalid = 1'b0; dc_rdata = 32'h0;
    @(posedge clk); #1;
    check_bit("rst_req", dc_req, 1'b0);
    check_bit("rst_stall", stall_cache, 1'b0);
    check_bit("rst_ldv", ld_valid, 1'b0);
    check_bit("rst_exc", acc_exc, 1'b0);
    check_bit("rst_we", dc_we, 1'b0);
    check("rst_ld_data", ld_data, 32'h0);
    check("rst_exc_pc", exc_pc, 32'h0);
    check("rst_exc_addr", exc_addr, 32'h0);
    check("rst_addr", dc_addr, 32'h0);
    check("rst_wdata", dc_wdata, 32'h0);
    check("rst_wstrb", {28'h0, dc_wstrb}, 32'h0);
    valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;

    // Basic LW, 3-cycle latency
    run_op(1, 1, 0, 3'b010, 32'h100, 32'h0, 32'h10, 32'hDEADBEEF, 0, 0, 0);
    check("lw_const", ld_data, 32'hDEADBEEF);
    // Sub-word loads from the top lanes
    run_op(1, 1, 0, 3'b000, 32'h103, 32'h0, 32'h14, 32'h80FF_0000, 1, 1, 0);
    check("lb_const", ld_data, 32'hFFFFFF80);
    run_op(1, 1, 0, 3'b100, 32'h103, 32'h0, 32'h18, 32'h80FF_0000, 0, 2, 0);
    check("lbu_const", ld_data, 32'h00000080);
    run_op(1, 1, 0, 3'b101, 32'h102, 32'h0, 32'h1C, 32'h80FF_0000, 2, 0, 0);
    check("lhu_const", ld_data, 32'h000080FF);
    // SB leaves ld_data alone
    run_op(1, 0, 1, 3'b000, 32'h201, 32'h000000A5, 32'h20, 32'h0, 1, 0, 0);
    check("sb_ld_hold", ld_data, 32'h000080FF);
    // Misaligned LW
    run_op(1, 1, 0, 3'b010, 32'h102, 32'h0, 32'h40, 32'h0, 0, 0, 0);
    check("exc_pc_const", exc_pc, 32'h40);
    // Accept and response in the same cycle
    run_op(1, 1, 0, 3'b010, 32'h104, 32'h0, 32'h44, 32'h12345678, 0, 0, 1);
    // Read wins over write
    run_op(1, 1, 1, 3'b010, 32'h108, 32'hFFFFFFFF, 32'h48, 32'h0BADF00D, 0, 0, 0);
    run_op(1, 0, 1, 3'b001, 32'h206, 32'hBEEF1234, 32'h4C, 32'h0, 0, 1, 0);
    run_op(1, 0, 1, 3'b010, 32'h20C, 32'hCAFEBABE, 32'h50, 32'h0, 3, 0, 1);
    run_op(1, 1, 0, 3'b001, 32'h102, 32'h0, 32'h54, 32'h80FF_0000, 0, 0, 0);
    check("lh_const", ld_data, 32'hFFFF80FF);
    // Illegal encodings and alignment
    run_op(1, 0, 1, 3'b001, 32'h201, 32'h1, 32'h58, 32'h0, 0, 0, 0);
    run_op(1, 0, 1, 3'b100, 32'h200, 32'h1, 32'h5C, 32'h0, 0, 0, 0);
    run_op(1, 1, 0, 3'b011, 32'h200, 32'h0, 32'h60, 32'h0, 0, 0, 0);
    run_op(1, 1, 0, 3'b110, 32'h200, 32'h0, 32'h64, 32'h0, 0, 0, 0);
    // No live access
    run_op(0, 1, 0, 3'b010, 32'h300, 32'h0, 32'h68, 32'h0, 0, 0, 0);
    run_op(1, 0, 0, 3'b010, 32'h300, 32'h0, 32'h6C, 32'h0, 0, 0, 0);

    // Long stall in REQ, then reset in WAIT with an orphan response afterwards
    valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010;
    alu_out_in = 32'h300; current_pc_in = 32'h70; dc_ready = 1'b0; dc_rvalid = 1'b0;
    @(negedge clk);
    check_bit("hold_idle_stall", stall_cache, 1'b1);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_bit("hold_req", dc_req, 1'b1);
      check("hold_addr", dc_addr, 32'h300);
      check_bit("hold_stall", stall_cache, 1'b1);
      @(posedge clk); #1;
    end
    dc_ready = 1'b1;
    @(posedge clk); #1;
    dc_ready = 1'b0;
    @(negedge clk);
    check_bit("wait_pre_rst_stall", stall_cache, 1'b1);
    #1 rst = 1'b0;
    #1;
    check_bit("rst_mid_req", dc_req, 1'b0);
    check_bit("rst_mid_stall", stall_cache, 1'b0);
    check("rst_mid_ld", ld_data, 32'h0);
    check("rst_mid_exc_pc", exc_pc, 32'h0);
    check("rst_mid_exc_addr", exc_addr, 32'h0);
    model_ld = 32'h0;
    valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    dc_rvalid = 1'b1; dc_rdata = 32'hCAFEF00D;
    @(negedge clk);
    check_bit("orphan_ldv", ld_valid, 1'b0);
    check_bit("orphan_req", dc_req, 1'b0);
    @(posedge clk); #1;
    dc_rvalid = 1'b0;
    @(negedge clk);
    check_bit("orphan_ldv2", ld_valid, 1'b0);
    check("orphan_ld", ld_data, 32'h0);
    @(posedge clk); #1;

    // Randomized traffic against the model
    for (int n = 0; n < 60; n++) begin
      r_f3   = 3'($urandom_range(0, 7));
      r_addr = $urandom;
      if ($urandom_range(0, 1) == 1) r_addr = r_addr & 32'hFFFF_FFFC;
      r_vld  = ($urandom_range(0, 7) != 0);
      r_rd   = 1'($urandom_range(0, 1));
      r_wr   = 1'($urandom_range(0, 1));
      run_op(r_vld, r_rd, r_wr, r_f3, r_addr, $urandom, $urandom, $urandom,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             bit'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
